// File: rtl/datapath_pkg.sv
// Shared datapath definitions: default operand/slice widths and the
// state encoding used by the multi-cycle wrappers.
package datapath_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

endpackage

// File: rtl/seq_sub_16bit_rca.sv
// Ripple-carry slice adder: sum = a + b + cin, carry out of the top bit.
module RCA_4bit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[W];

endmodule

// File: rtl/seq_sub_16bit.sv
// Multi-cycle subtractor: in1 - in2 - bin computed one slice per cycle,
// LSB first, through a single shared ripple-carry slice.
module seq_sub_16bit
  import datapath_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             bout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam int MSB = WIDTH - 1;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [WIDTH-1:0] a_reg, b_reg, part_reg, part_next;
  logic             carry_reg;
  logic [SLICE-1:0] a_slice, b_slice_inv, sum_slice;
  logic             slice_cout;
  logic             last_slice, accept;

  // Subtraction as a + ~b + carry, where the carry starts as ~bin.
  assign a_slice     = a_reg[idx_reg*SLICE +: SLICE];
  assign b_slice_inv = ~b_reg[idx_reg*SLICE +: SLICE];

  RCA_4bit #(.W(SLICE)) u_slice (
    .a   (a_slice),
    .b   (b_slice_inv),
    .cin (carry_reg),
    .sum (sum_slice),
    .cout(slice_cout)
  );

  always_comb begin
    part_next = part_reg;
    part_next[idx_reg*SLICE +: SLICE] = sum_slice;
  end

  // FIN accepts a new start just like IDLE, giving back-to-back operation.
  assign accept     = start && (state_reg != ST_RUN);
  assign last_slice = (idx_reg == LAST_IDX);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_FIN: state_next = start ? ST_RUN : ST_IDLE;
      ST_RUN:          if (last_slice) state_next = ST_FIN;
      default:         state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      part_reg  <= '0;
      carry_reg <= 1'b0;
      out       <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= in1;
        b_reg     <= in2;
        carry_reg <= ~bin;
        idx_reg   <= '0;
      end else if (state_reg == ST_RUN) begin
        carry_reg <= slice_cout;
        idx_reg   <= idx_reg + 1'b1;
        part_reg  <= part_next;
        // Visible result only moves on the completing edge.
        if (last_slice) begin
          out  <= part_next;
          bout <= ~slice_cout;
          ovf  <= (a_reg[MSB] != b_reg[MSB]) && (part_next[MSB] != a_reg[MSB]);
        end
      end
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_FIN);

endmodule

// File: tb/tb_seq_sub_16bit.sv
// Self-checking bench for seq_sub_16bit: directed corner cases plus random
// operands against an arithmetic reference model.
module tb_seq_sub_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in1 = '0, in2 = '0;
  logic        bin = 1'b0;
  logic        busy, done, bout, ovf;
  logic [15:0] out;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] held_out  = '0;
  logic        held_bout = 1'b0;
  logic        held_ovf  = 1'b0;

  always #5 clk = ~clk;

  seq_sub_16bit dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in1  (in1),
    .in2  (in2),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .out  (out),
    .bout (bout),
    .ovf  (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bi,
                       output logic [15:0] r, output logic br, output logic ov);
    int ud, sd;
    ud = int'(a) - int'(b) - int'(bi);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bi);
    r  = ud[15:0];
    br = (ud < 0);
    ov = (sd > 32767) || (sd < -32768);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                        input bit poke, input bit hold, input int gap);
    logic [15:0] er;
    logic        eb, eo;
    repeat (gap) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end
    model(a, b, bi, er, eb, eo);
    @(negedge clk);
    in1 = a; in2 = b; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    in1 = 16'($urandom); in2 = 16'($urandom); bin = 1'($urandom);
    check("run_busy", busy, 1);
    check("run_done", done, 0);
    for (int i = 1; i < 4; i++) begin
      if (poke && i == 2) begin
        start = 1'b1;
        in1 = 16'($urandom); in2 = 16'($urandom); bin = 1'($urandom);
      end
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("out_hold", out, held_out);
      check("bout_hold", bout, held_bout);
      check("ovf_hold", ovf, held_ovf);
    end
    @(posedge clk); #1;
    check("fin_done", done, 1);
    check("fin_busy", busy, 0);
    check("out", out, er);
    check("bout", bout, eb);
    check("ovf", ovf, eo);
    $display("op %h - %h - %0d -> out=%h bout=%0d ovf=%0d (model %h %0d %0d)",
             a, b, bi, out, bout, ovf, er, eb, eo);
    held_out = er; held_bout = eb; held_ovf = eo;
  endtask

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", out, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b1;

    run_op(16'h1234, 16'h0234, 1'b0, 0, 0, 1);
    run_op(16'h0000, 16'h0001, 1'b0, 0, 0, 1);
    run_op(16'h8000, 16'h0001, 1'b0, 0, 0, 2);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 0, 1);
    run_op(16'h0005, 16'h0003, 1'b1, 0, 0, 1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 0, 1);
    run_op(16'h8000, 16'h0000, 1'b1, 0, 0, 1);
    // start during RUN must be ignored
    run_op(16'h4321, 16'h1111, 1'b0, 1, 0, 1);
    // back-to-back: start held through FIN
    run_op(16'hABCD, 16'h1234, 1'b1, 0, 1, 1);
    run_op(16'h0F0F, 16'hF0F0, 1'b0, 0, 0, 0);
    run_op(16'h2222, 16'h3333, 1'b0, 0, 0, 0);

    for (int k = 0; k < 24; k++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
             0, $urandom_range(0, 2));

    // Asynchronous reset two cycles into RUN
    @(negedge clk);
    in1 = 16'h5555; in2 = 16'h1111; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_out", out, 0);
    check("arst_bout", bout, 0);
    check("arst_ovf", ovf, 0);
    held_out = '0; held_bout = 1'b0; held_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    run_op(16'h0010, 16'h0001, 1'b0, 0, 0, 0);

    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("end_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
